// File: rtl/pads_in_pkg.sv
// Shared constants for the pad input-conditioning block.
package pads_in_pkg;

  localparam int            CNT_W_DEF   = 16;     // debounce counter width default
  localparam int            GLITCH_W    = 8;      // rejected-glitch counter width
  localparam logic [7:0]    GLITCH_SAT  = 8'hFF;  // glitch counter holds here
  localparam logic          RST_VAL_DEF = 1'b0;   // per-channel reset level default

  // Saturating increment for the glitch counters.
  function automatic logic [GLITCH_W-1:0] sat_inc(input logic [GLITCH_W-1:0] v);
    return (v == GLITCH_SAT) ? v : v + GLITCH_W'(1);
  endfunction

endpackage

// File: rtl/pads_in_debounce.sv
// One input channel: synchroniser chain, optional debounce counter,
// registered level with rise/fall pulses, optional glitch counter
// (enabled by defining PADS_IN_GLITCH_CNT_EN).
module pads_in_debounce
  import pads_in_pkg::*;
#(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter int   CNT_W           = CNT_W_DEF,
  parameter logic RST_VAL         = RST_VAL_DEF
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                pad_i,
  input  logic                db_en_i,
  input  logic                glitch_clr_i,
  output logic                dout_o,
  output logic                rise_o,
  output logic                fall_o,
  output logic [GLITCH_W-1:0] glitch_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   dout_q, dout_d;
  logic                   rise_q, fall_q;
  logic                   abort;

  assign s = sync_q[SYNC_STAGES-1];

  // Synchroniser chain; the pad enters at bit 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) sync_q <= {SYNC_STAGES{RST_VAL}};
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], pad_i};
  end

  // Debounce decision: count while the synced level disagrees with dout,
  // commit on the last count, and flag an abort when it agrees again early.
  always_comb begin
    cnt_d  = '0;
    dout_d = dout_q;
    abort  = 1'b0;
    if (!db_en_i) begin
      dout_d = s;
    end else if (s != dout_q) begin
      if (cnt_q == CNT_LAST) dout_d = s;
      else                   cnt_d  = cnt_q + CNT_W'(1);
    end else begin
      abort = (cnt_q != '0);
    end
  end

  // Level, counter and edge pulses; pulses compare new vs. current level.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      dout_q <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
      rise_q <= dout_d & ~dout_q;
      fall_q <= ~dout_d & dout_q;
    end
  end

  assign dout_o = dout_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

`ifdef PADS_IN_GLITCH_CNT_EN
  logic [GLITCH_W-1:0] gcnt_q;

  // Rejected-glitch counter; clear beats a same-cycle increment.
  always_ff @(posedge clk_i) begin
    if (rst_i || glitch_clr_i) gcnt_q <= '0;
    else if (abort)            gcnt_q <= sat_inc(gcnt_q);
  end

  assign glitch_cnt_o = gcnt_q;
`else
  logic unused_glitch;
  assign unused_glitch = glitch_clr_i ^ abort;
  assign glitch_cnt_o  = '0;
`endif

endmodule

// File: rtl/pads_in_cond.sv
// Input-conditioning stage for the pad-cell core-side outputs.
// One pads_in_debounce per channel; this level only slices vectors.
// Define PADS_IN_GLITCH_CNT_EN to build the per-channel glitch counters.
module pads_in_cond
  import pads_in_pkg::*;
#(
  parameter int              N_CH            = 8,
  parameter int              SYNC_STAGES     = 2,
  parameter int              DEBOUNCE_CYCLES = 50000,
  parameter int              CNT_W           = CNT_W_DEF,
  parameter logic [N_CH-1:0] RST_VAL         = {N_CH{RST_VAL_DEF}}
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_CH-1:0]            pad_c,
  input  logic [N_CH-1:0]            db_en,
  output logic [N_CH-1:0]            dout,
  output logic [N_CH-1:0]            rise,
  output logic [N_CH-1:0]            fall,
  input  logic                       glitch_clr,
  output logic [GLITCH_W*N_CH-1:0]   glitch_cnt
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    pads_in_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W),
      .RST_VAL         (RST_VAL[i])
    ) u_ch (
      .clk_i        (clk),
      .rst_i        (rst),
      .pad_i        (pad_c[i]),
      .db_en_i      (db_en[i]),
      .glitch_clr_i (glitch_clr),
      .dout_o       (dout[i]),
      .rise_o       (rise[i]),
      .fall_o       (fall[i]),
      .glitch_cnt_o (glitch_cnt[GLITCH_W*i +: GLITCH_W])
    );
  end

endmodule

// File: tb/tb_pads_in_cond.sv
// Bench for pads_in_cond: N_CH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, db_en=1110.
module tb_pads_in_cond;

  localparam int N = 4;
`ifdef PADS_IN_GLITCH_CNT_EN
  localparam bit GEN = 1'b1;
`else
  localparam bit GEN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           glitch_clr;
  logic [N-1:0]   pad_c, db_en, dout, rise, fall;
  logic [8*N-1:0] glitch_cnt;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int         due;
    logic [3:0] mask;
    logic [3:0] dout;
    logic [3:0] rise;
    logic [3:0] fall;
    string      name;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic       rst;
    logic [3:0] pad;
    logic [3:0] dout;
    logic [3:0] rise;
    logic [3:0] fall;
  } vec_t;
  vec_t vt[17];

  pads_in_cond #(
    .N_CH(N), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .CNT_W(16), .RST_VAL(4'b0000)
  ) dut (
    .clk(clk), .rst(rst), .pad_c(pad_c), .db_en(db_en),
    .dout(dout), .rise(rise), .fall(fall),
    .glitch_clr(glitch_clr), .glitch_cnt(glitch_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard: compare every expectation that falls due this cycle
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        checks++;
        if (((dout & sb[i].mask) !== (sb[i].dout & sb[i].mask)) ||
            ((rise & sb[i].mask) !== (sb[i].rise & sb[i].mask)) ||
            ((fall & sb[i].mask) !== (sb[i].fall & sb[i].mask))) begin
          failures++;
          $display("FAIL %s cyc=%0d mask=%b got dout=%b rise=%b fall=%b want dout=%b rise=%b fall=%b",
                   sb[i].name, cyc, sb[i].mask, dout, rise, fall,
                   sb[i].dout, sb[i].rise, sb[i].fall);
        end
        sb.delete(i);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int due, input logic [3:0] m, input logic [3:0] d,
                           input logic [3:0] r, input logic [3:0] f, input string n);
    exp_t e;
    e.due = due; e.mask = m; e.dout = d; e.rise = r; e.fall = f; e.name = n;
    sb.push_back(e);
  endtask

  task automatic check_val(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", n, act, exp);
    end
  endtask

  initial begin
    int k;
    rst = 1'b1; pad_c = 4'hF; db_en = 4'b1110; glitch_clr = 1'b0;

    // reset with pads high, release, then ch0 fall/rise through bypass
    vt[0]  = '{1'b1, 4'hF, 4'h0, 4'h0, 4'h0};
    vt[1]  = '{1'b1, 4'hF, 4'h0, 4'h0, 4'h0};
    vt[2]  = '{1'b1, 4'hF, 4'h0, 4'h0, 4'h0};
    vt[3]  = '{1'b0, 4'hF, 4'h0, 4'h0, 4'h0};
    vt[4]  = '{1'b0, 4'hF, 4'h0, 4'h0, 4'h0};
    vt[5]  = '{1'b0, 4'hF, 4'h1, 4'h1, 4'h0};
    vt[6]  = '{1'b0, 4'hF, 4'h1, 4'h0, 4'h0};
    vt[7]  = '{1'b0, 4'hF, 4'h1, 4'h0, 4'h0};
    vt[8]  = '{1'b0, 4'hF, 4'hF, 4'hE, 4'h0};
    vt[9]  = '{1'b0, 4'hF, 4'hF, 4'h0, 4'h0};
    vt[10] = '{1'b0, 4'hE, 4'hF, 4'h0, 4'h0};
    vt[11] = '{1'b0, 4'hE, 4'hF, 4'h0, 4'h0};
    vt[12] = '{1'b0, 4'hE, 4'hE, 4'h0, 4'h1};
    vt[13] = '{1'b0, 4'hF, 4'hE, 4'h0, 4'h0};
    vt[14] = '{1'b0, 4'hF, 4'hE, 4'h0, 4'h0};
    vt[15] = '{1'b0, 4'hF, 4'hF, 4'h1, 4'h0};
    vt[16] = '{1'b0, 4'hF, 4'hF, 4'h0, 4'h0};

    tick(1);
    for (int i = 0; i < 17; i++) begin
      rst   = vt[i].rst;
      pad_c = vt[i].pad;
      expect_at(cyc + 1, 4'hF, vt[i].dout, vt[i].rise, vt[i].fall, $sformatf("vec%0d", i));
      tick(1);
    end
    check_val("t1_gcnt", glitch_cnt, 32'd0);

    // ch1 debounced fall: nothing before t+6
    k = cyc;
    pad_c = 4'b1101;
    for (int d = 1; d <= 5; d++) expect_at(k + d, 4'b0010, 4'b0010, 4'b0000, 4'b0000, "t3_hold");
    expect_at(k + 6, 4'b0010, 4'b0000, 4'b0000, 4'b0010, "t3_fall");
    expect_at(k + 7, 4'b0010, 4'b0000, 4'b0000, 4'b0000, "t3_fall_end");
    tick(8);

    // ch2 low, then a 3-cycle high glitch that must be rejected
    pad_c = 4'b1001;
    tick(8);
    k = cyc;
    pad_c = 4'b1101;
    for (int d = 1; d <= 12; d++) expect_at(k + d, 4'b0100, 4'b0000, 4'b0000, 4'b0000, "t4_glitch");
    tick(3);
    pad_c = 4'b1001;
    tick(9);
    check_val("t4_gcnt", glitch_cnt[23:16], GEN ? 32'd1 : 32'd0);

    // ch3 mid-count reset discards the partial count
    pad_c = 4'b0001;
    tick(8);
    k = cyc;
    pad_c = 4'b1001;
    for (int d = 1; d <= 10; d++) expect_at(k + d, 4'b1000, 4'b0000, 4'b0000, 4'b0000, "t5_pre");
    expect_at(k + 11, 4'b1000, 4'b1000, 4'b1000, 4'b0000, "t5_rise");
    expect_at(k + 12, 4'b1000, 4'b1000, 4'b0000, 4'b0000, "t5_rise_end");
    tick(4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(8);
    check_val("t5_gcnt_rst", glitch_cnt, 32'd0);

    // 260 short glitches on ch1 saturate its counter
    for (int g = 0; g < 260; g++) begin
      pad_c[1] = 1'b1;
      tick(2);
      pad_c[1] = 1'b0;
      tick(5);
    end
    check_val("t6_dout1", dout[1], 32'd0);
    check_val("t6_gcnt_sat", glitch_cnt[15:8], GEN ? 32'd255 : 32'd0);

    // clear lands on the same edge as another abort
    pad_c[1] = 1'b1;
    tick(2);
    pad_c[1] = 1'b0;
    tick(2);
    glitch_clr = 1'b1;
    tick(1);
    glitch_clr = 1'b0;
    tick(3);
    check_val("t6_clr", glitch_cnt[15:8], 32'd0);

    tick(2);
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL sb_leftover got=%0d want=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
